// File: rtl/lockin_demod.sv
// lockin_demod: I/Q lock-in demodulator with integrate-and-dump.
// Each ADC sample is multiplied by the DDS cosine (I) and sine (Q). The
// products are summed over a programmable window of samples. At the end of
// each window the sums are shifted, saturated and offered on a valid/ready
// output.
// Optional build macro LOCKIN_ADC_OFFSET_EN adds an adc_offset port. When it
// is defined, the offset is subtracted from the sample at capture time.
`timescale 1ns/1ps

module lockin_demod #(
   parameter int ADC_WIDTH = 14,
   parameter int LO_WIDTH  = 16,
   parameter int ACC_WIDTH = 48,
   parameter int OUT_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic signed [ADC_WIDTH-1:0] adc_in,
`ifdef LOCKIN_ADC_OFFSET_EN
   input  logic signed [ADC_WIDTH-1:0] adc_offset,
`endif
   input  logic                        adc_valid,
   input  logic signed [LO_WIDTH-1:0]  sin_in,
   input  logic signed [LO_WIDTH-1:0]  cos_in,
   input  logic                        sync_i,
   input  logic [15:0]                 dec_len,
   input  logic [5:0]                  shift,
   output logic signed [OUT_WIDTH-1:0] i_out,
   output logic signed [OUT_WIDTH-1:0] q_out,
   output logic                        out_valid,
   input  logic                        out_ready,
   input  logic                        clr_ovr,
   output logic                        overrun
);

   localparam int PROD_WIDTH = ADC_WIDTH + LO_WIDTH;

   // Clamp a one-bit-extended difference back into the ADC range.
   function automatic logic signed [ADC_WIDTH-1:0] sat_adc(input logic signed [ADC_WIDTH:0] x);
      if (x[ADC_WIDTH] != x[ADC_WIDTH-1])
         return x[ADC_WIDTH] ? $signed({1'b1, {(ADC_WIDTH-1){1'b0}}})
                             : $signed({1'b0, {(ADC_WIDTH-1){1'b1}}});
      else
         return $signed(x[ADC_WIDTH-1:0]);
   endfunction

   // Clamp a shifted accumulator value into the output range.
   function automatic logic signed [OUT_WIDTH-1:0] sat_out(input logic signed [ACC_WIDTH-1:0] x);
      logic [ACC_WIDTH-OUT_WIDTH:0] top;
      top = x[ACC_WIDTH-1:OUT_WIDTH-1];
      if (top == '0 || top == '1)
         return $signed(x[OUT_WIDTH-1:0]);
      else if (x[ACC_WIDTH-1])
         return $signed({1'b1, {(OUT_WIDTH-1){1'b0}}});
      else
         return $signed({1'b0, {(OUT_WIDTH-1){1'b1}}});
   endfunction

   logic signed [ADC_WIDTH-1:0] adc_cap;
`ifdef LOCKIN_ADC_OFFSET_EN
   logic signed [ADC_WIDTH:0] adc_diff;
   assign adc_diff = {adc_in[ADC_WIDTH-1], adc_in} - {adc_offset[ADC_WIDTH-1], adc_offset};
   assign adc_cap  = sat_adc(adc_diff);
`else
   assign adc_cap  = adc_in;
`endif

   logic signed [ADC_WIDTH-1:0]  adc_p0;
   logic signed [LO_WIDTH-1:0]   sin_p0, cos_p0;
   logic                         vld_p0;
   logic signed [PROD_WIDTH-1:0] prod_i_p1, prod_q_p1;
   logic                         vld_p1;
   logic signed [ACC_WIDTH-1:0]  acc_i_p2, acc_q_p2, sum_i_p2, sum_q_p2;
   logic                         dump_p2;
   logic [15:0]                  cnt_p2, len_m1;
   logic                         len_load;

   logic signed [ACC_WIDTH-1:0] next_i, next_q;
   logic [15:0]                 len_next;
   logic                        accept;

   assign next_i   = acc_i_p2 + ACC_WIDTH'(prod_i_p1);
   assign next_q   = acc_q_p2 + ACC_WIDTH'(prod_q_p1);
   // A window length of zero behaves as a one-sample window.
   assign len_next = (dec_len == 16'd0) ? 16'd0 : dec_len - 16'd1;
   assign accept   = out_valid && out_ready;

   // ---- stage 1 / stage 2 data: capture sample, then form full-width products
   // Sample and product registers carry data only; their valid bits live below.
   always_ff @(posedge clk) begin
      if (adc_valid) begin
         adc_p0 <= adc_cap;
         sin_p0 <= sin_in;
         cos_p0 <= cos_in;
      end
      prod_i_p1 <= PROD_WIDTH'(adc_p0) * PROD_WIDTH'(cos_p0);
      prod_q_p1 <= PROD_WIDTH'(adc_p0) * PROD_WIDTH'(sin_p0);
   end

   // Valid bits for stages 1 and 2; sync drops the sample between them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p0 <= adc_valid;
         vld_p1 <= vld_p0 && !sync_i;
      end
   end

   // ---- stage 3: integrate, count the window, dump the final sum
   // The window length is latched only at reset, sync and dump.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_i_p2 <= '0;
         acc_q_p2 <= '0;
         sum_i_p2 <= '0;
         sum_q_p2 <= '0;
         cnt_p2   <= '0;
         len_m1   <= '0;
         len_load <= 1'b1;
         dump_p2  <= 1'b0;
      end else begin
         dump_p2 <= 1'b0;
         if (len_load) begin
            len_m1   <= len_next;
            len_load <= 1'b0;
         end
         if (sync_i) begin
            acc_i_p2 <= '0;
            acc_q_p2 <= '0;
            cnt_p2   <= '0;
            len_m1   <= len_next;
         end else if (vld_p1) begin
            if (cnt_p2 == len_m1) begin
               sum_i_p2 <= next_i;
               sum_q_p2 <= next_q;
               dump_p2  <= 1'b1;
               acc_i_p2 <= '0;
               acc_q_p2 <= '0;
               cnt_p2   <= '0;
               len_m1   <= len_next;
            end else begin
               acc_i_p2 <= next_i;
               acc_q_p2 <= next_q;
               cnt_p2   <= cnt_p2 + 16'd1;
            end
         end
      end
   end

   // ---- output stage: scale, saturate, hold under backpressure, flag overrun
   // A new result is loaded only when the output is empty or being accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_out     <= '0;
         q_out     <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (dump_p2 && (!out_valid || accept)) begin
            i_out     <= sat_out(sum_i_p2 >>> shift);
            q_out     <= sat_out(sum_q_p2 >>> shift);
            out_valid <= 1'b1;
         end else if (accept) begin
            out_valid <= 1'b0;
         end
         if (dump_p2 && out_valid && !out_ready)
            overrun <= 1'b1;
         else if (clr_ovr)
            overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lockin_demod.sv
// Directed testbench for lockin_demod with hand-computed expected results.
`timescale 1ns/1ps

module tb_lockin_demod;

   localparam int ADC_WIDTH = 14;
   localparam int LO_WIDTH  = 16;
   localparam int ACC_WIDTH = 48;
   localparam int OUT_WIDTH = 32;

   logic                        clk = 1'b0;
   logic                        rst_n;
   logic signed [ADC_WIDTH-1:0] adc_in;
   logic                        adc_valid;
   logic signed [LO_WIDTH-1:0]  sin_in, cos_in;
   logic                        sync_i;
   logic [15:0]                 dec_len;
   logic [5:0]                  shift;
   logic signed [OUT_WIDTH-1:0] i_out, q_out;
   logic                        out_valid;
   logic                        out_ready;
   logic                        clr_ovr;
   logic                        overrun;
`ifdef LOCKIN_ADC_OFFSET_EN
   logic signed [ADC_WIDTH-1:0] adc_offset = '0;
`endif

   int checks = 0;
   int errors = 0;

   lockin_demod #(
      .ADC_WIDTH(ADC_WIDTH), .LO_WIDTH(LO_WIDTH),
      .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .adc_in(adc_in),
`ifdef LOCKIN_ADC_OFFSET_EN
      .adc_offset(adc_offset),
`endif
      .adc_valid(adc_valid), .sin_in(sin_in), .cos_in(cos_in),
      .sync_i(sync_i), .dec_len(dec_len), .shift(shift),
      .i_out(i_out), .q_out(q_out), .out_valid(out_valid),
      .out_ready(out_ready), .clr_ovr(clr_ovr), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int a, input int c, input int s, input logic v);
      adc_in    = ADC_WIDTH'(a);
      cos_in    = LO_WIDTH'(c);
      sin_in    = LO_WIDTH'(s);
      adc_valid = v;
   endtask

   // Restart the window with a new length/shift and drain any held output.
   task automatic flush(input int len, input int sh);
      adc_valid = 1'b0;
      dec_len   = 16'(len);
      shift     = 6'(sh);
      sync_i    = 1'b1;
      tick();
      sync_i    = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 1'b0);
      sync_i = 1'b0; dec_len = 16'd4; shift = 6'd0;
      out_ready = 1'b1; clr_ovr = 1'b0;
      #12;
      chk("reset_valid", out_valid, 0);
      chk("reset_i", i_out, 0);
      chk("reset_q", q_out, 0);
      chk("reset_ovr", overrun, 0);
      rst_n = 1'b1;

      // Window of 4, continuous samples: a result every 4 cycles, first after edge 7
      drive(1000, 16384, -16384, 1'b1);
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("w4_valid", out_valid, (k >= 7 && (k - 7) % 4 == 0) ? 1 : 0);
         if (k >= 7 && (k - 7) % 4 == 0) begin
            chk("w4_i", i_out, 65536000);
            chk("w4_q", q_out, -65536000);
         end
      end

      // Saturation at shift 0
      flush(16, 0);
      drive(8191, 32767, -32768, 1'b1);
      repeat (16) tick();
      adc_valid = 1'b0;
      repeat (2) tick();
      chk("sat_early", out_valid, 0);
      tick();
      chk("sat_valid", out_valid, 1);
      chk("sat_i", i_out, 64'sd2147483647);
      chk("sat_q", q_out, -64'sd2147483648);

      // Backpressure: first pair held, later dumps dropped, overrun set
      flush(2, 0);
      out_ready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         drive(k, 1, -1, 1'b1);
         tick();
      end
      adc_valid = 1'b0;
      repeat (3) tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_i", i_out, 3);
      chk("bp_q", q_out, -3);
      chk("bp_ovr", overrun, 1);
      out_ready = 1'b1;
      tick();
      chk("bp_accept", out_valid, 0);
      chk("bp_ovr_sticky", overrun, 1);
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      chk("bp_ovr_clr", overrun, 0);

      // dec_len 0 acts as 1: every sample dumps, valid stays high
      flush(0, 0);
      drive(-3, 2, 0, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("len0_valid", out_valid, (k >= 4) ? 1 : 0);
         if (k >= 4) chk("len0_i", i_out, -6);
      end
      adc_valid = 1'b0;
      chk("len0_ovr", overrun, 0);

      // Sync mid-window: partial discarded, coincident sample starts the new window
      flush(8, 0);
      for (int k = 1; k <= 5; k++) begin
         drive(100, 1, -1, 1'b1);
         tick();
      end
      drive(1, 1, -1, 1'b1);
      sync_i = 1'b1;
      tick();
      sync_i  = 1'b0;
      dec_len = 16'd3;
      for (int k = 2; k <= 8; k++) begin
         drive(k, 1, -1, 1'b1);
         tick();
      end
      adc_valid = 1'b0;
      repeat (2) tick();
      chk("sync_early", out_valid, 0);
      tick();
      chk("sync_valid", out_valid, 1);
      chk("sync_i", i_out, 36);
      chk("sync_q", q_out, -36);

      // Longest window with shift 16
      flush(65535, 16);
      drive(8191, 32767, -32768, 1'b1);
      repeat (65535) tick();
      adc_valid = 1'b0;
      repeat (2) tick();
      chk("long_early", out_valid, 0);
      tick();
      chk("long_valid", out_valid, 1);
      chk("long_i", i_out, 268390401);
      chk("long_q", q_out, -268398593);

      // Hold result under backpressure, force an overrun, then async reset mid-cycle
      out_ready = 1'b0;
      dec_len   = 16'd1;
      sync_i    = 1'b1;
      tick();
      sync_i = 1'b0;
      drive(5, 1, 1, 1'b1);
      repeat (4) tick();
      chk("hold_i", i_out, 268390401);
      chk("hold_ovr", overrun, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_valid", out_valid, 0);
      chk("areset_i", i_out, 0);
      chk("areset_q", q_out, 0);
      chk("areset_ovr", overrun, 0);
      adc_valid = 1'b0;
      #10;
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
